// File: rtl/bcd_split_n_if.sv
// Bus bundle for bcd_split_n: the conversion request/enable inputs and the
// result/status outputs. The master drives requests and the slave (converter) answers.
interface bcd_split_n_if #(
  parameter int IN_W   = 7,
  parameter int DIGITS = 3
);
  logic                  en;
  logic                  start;
  logic [IN_W-1:0]       number;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
  logic                  valid;
  logic                  ovf;

  modport master (
    output en, start, number,
    input  bcd, busy, done, valid, ovf
  );

  modport slave (
    input  en, start, number,
    output bcd, busy, done, valid, ovf
  );
endinterface

// File: rtl/bcd_split_n.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with a fixed latency of IN_W+2 cycles and saturation to all nines on overflow.
module bcd_split_n #(
  parameter int IN_W   = 7,
  parameter int DIGITS = 3,
  parameter bit AUTO   = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  bcd_split_n_if.slave bus
);
  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + 4;
  localparam int CAT_W  = WORK_W + IN_W;
  localparam int CNT_W  = $clog2(IN_W + 1);

  localparam int          MAX_VAL      = (10 ** DIGITS) - 1;
  localparam int          MAX_IN       = (2 ** IN_W) - 1;
  localparam bit          OVF_POSSIBLE = (MAX_IN > MAX_VAL);
  localparam logic [31:0] MAX_VAL_U    = 32'(MAX_VAL);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BCD_W-1:0] NINES    = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_r;
  logic [IN_W-1:0]    sh_r;
  logic [IN_W-1:0]    last_r;
  logic [WORK_W-1:0]  work_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [BCD_W-1:0]   bcd_r;
  logic               busy_r;
  logic               done_r;
  logic               valid_r;
  logic               ovf_r;

  logic               trig_s;
  logic               ovf_s;
  logic [WORK_W-1:0]  adj_s;
  logic [CAT_W-1:0]   shifted_s;

  // Add 3 to every nibble that is 5 or more, so the following left shift carries in decimal.
  function automatic logic [WORK_W-1:0] add3_nibbles(input logic [WORK_W-1:0] w);
    logic [WORK_W-1:0] r;
    r = w;
    for (int i = 0; i < WORK_W / 4; i++) begin
      if (w[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = w[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = w[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Conversion trigger: explicit start, or in self-start mode any reason the result is stale.
  always_comb begin
    trig_s = 1'b0;
    if (AUTO) begin
      trig_s = bus.start || !valid_r || (bus.number != last_r);
    end else begin
      trig_s = bus.start;
    end
  end

  // Overflow is a pure compare against the largest representable value, folded away when unreachable.
  always_comb begin
    ovf_s = 1'b0;
    if (OVF_POSSIBLE) begin
      ovf_s = (32'(bus.number) > MAX_VAL_U);
    end else begin
      ovf_s = 1'b0;
    end
  end

  // One shift-and-add-3 step over the concatenated {work, shift} register.
  always_comb begin
    adj_s     = add3_nibbles(work_r);
    shifted_s = {adj_s, sh_r} << 1;
  end

  // Control FSM with registered outputs; en low acts as a synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      sh_r    <= '0;
      last_r  <= '0;
      work_r  <= '0;
      cnt_r   <= '0;
      bcd_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (!bus.en) begin
      state_r <= IDLE;
      sh_r    <= '0;
      last_r  <= '0;
      work_r  <= '0;
      cnt_r   <= '0;
      bcd_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (trig_s) begin
            sh_r    <= bus.number;
            last_r  <= bus.number;
            work_r  <= '0;
            cnt_r   <= '0;
            ovf_r   <= ovf_s;
            valid_r <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          work_r <= shifted_s[CAT_W-1:IN_W];
          sh_r   <= shifted_s[IN_W-1:0];
          cnt_r  <= cnt_r + CNT_ONE;
          if (cnt_r == LAST_CNT) begin
            state_r <= DONE;
          end else begin
            state_r <= SHIFT;
          end
        end
        DONE: begin
          if (ovf_r) begin
            bcd_r <= NINES;
          end else begin
            bcd_r <= work_r[BCD_W-1:0];
          end
          done_r  <= 1'b1;
          valid_r <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.bcd   = bcd_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.valid = valid_r;
  assign bus.ovf   = ovf_r;
endmodule

// File: tb/tb_bcd_split_n.sv
// Directed bench for bcd_split_n: default, two-digit and self-start instances,
// table-driven conversions plus abort, reset and auto-trigger sequences.
module tb_bcd_split_n;
  logic clk;
  logic rst_n;

  bcd_split_n_if #(.IN_W(7), .DIGITS(3)) i0 ();
  bcd_split_n_if #(.IN_W(7), .DIGITS(2)) i2 ();
  bcd_split_n_if #(.IN_W(7), .DIGITS(3)) ia ();

  bcd_split_n #(.IN_W(7), .DIGITS(3), .AUTO(1'b0)) u_d0 (.clk(clk), .rst_n(rst_n), .bus(i0));
  bcd_split_n #(.IN_W(7), .DIGITS(2), .AUTO(1'b0)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(i2));
  bcd_split_n #(.IN_W(7), .DIGITS(3), .AUTO(1'b1)) u_da (.clk(clk), .rst_n(rst_n), .bus(ia));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [11:0] o_bcd;
  logic        o_busy;
  logic        o_done;
  logic        o_valid;
  logic        o_ovf;

  typedef struct {
    int          w;
    logic [6:0]  num;
    logic [11:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int w);
    case (w)
      0: begin
        o_bcd = i0.bcd; o_busy = i0.busy; o_done = i0.done; o_valid = i0.valid; o_ovf = i0.ovf;
      end
      1: begin
        o_bcd = {4'h0, i2.bcd}; o_busy = i2.busy; o_done = i2.done; o_valid = i2.valid; o_ovf = i2.ovf;
      end
      default: begin
        o_bcd = ia.bcd; o_busy = ia.busy; o_done = ia.done; o_valid = ia.valid; o_ovf = ia.ovf;
      end
    endcase
  endtask

  task automatic drive(input int w, input logic st, input logic [6:0] num);
    case (w)
      0: begin i0.start = st; i0.number = num; end
      1: begin i2.start = st; i2.number = num; end
      default: begin ia.start = st; ia.number = num; end
    endcase
  endtask

  // Start one conversion in the current cycle and follow it to its done pulse.
  task automatic conv(input int w, input logic [6:0] num, input logic [11:0] exp_bcd,
                      input logic exp_ovf, input logic [11:0] prev_bcd);
    int cyc;
    int bc;
    drive(w, 1'b1, num);
    tick();
    drive(w, 1'b0, num);
    sample(w);
    check("accept_busy", 32'(o_busy), 32'd1);
    check("accept_valid", 32'(o_valid), 32'd0);
    check("accept_done", 32'(o_done), 32'd0);
    check("hold_bcd", 32'(o_bcd), 32'(prev_bcd));
    cyc = 1;
    bc  = 0;
    while (!o_done && cyc < 30) begin
      if (o_busy) bc++;
      tick();
      cyc++;
      sample(w);
    end
    check("latency", 32'(cyc), 32'd9);
    check("busy_cycles", 32'(bc), 32'd8);
    check("bcd", 32'(o_bcd), 32'(exp_bcd));
    check("ovf", 32'(o_ovf), 32'(exp_ovf));
    check("valid", 32'(o_valid), 32'd1);
    check("busy_at_done", 32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [11:0] prev[3];
    int          nd;
    logic [11:0] cap[2];

    vecs[0]  = '{0, 7'd127, 12'h127, 1'b0};
    vecs[1]  = '{0, 7'd0,   12'h000, 1'b0};
    vecs[2]  = '{0, 7'd99,  12'h099, 1'b0};
    vecs[3]  = '{0, 7'd64,  12'h064, 1'b0};
    vecs[4]  = '{0, 7'd100, 12'h100, 1'b0};
    vecs[5]  = '{0, 7'd5,   12'h005, 1'b0};
    vecs[6]  = '{1, 7'd100, 12'h099, 1'b1};
    vecs[7]  = '{1, 7'd42,  12'h042, 1'b0};
    vecs[8]  = '{1, 7'd127, 12'h099, 1'b1};
    vecs[9]  = '{1, 7'd99,  12'h099, 1'b0};
    vecs[10] = '{1, 7'd7,   12'h007, 1'b0};
    prev[0] = 12'h000;
    prev[1] = 12'h000;
    prev[2] = 12'h000;

    rst_n = 1'b0;
    i0.en = 1'b1; i0.start = 1'b1; i0.number = 7'd127;
    i2.en = 1'b1; i2.start = 1'b0; i2.number = 7'd0;
    ia.en = 1'b0; ia.start = 1'b0; ia.number = 7'd0;
    repeat (3) tick();
    sample(0);
    check("rst_bcd", 32'(o_bcd), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ovf", 32'(o_ovf), 32'd0);
    rst_n = 1'b1;

    // First vector is accepted on the very first edge after reset release.
    for (int i = 0; i < 11; i++) begin
      conv(vecs[i].w, vecs[i].num, vecs[i].exp_bcd, vecs[i].exp_ovf, prev[vecs[i].w]);
      prev[vecs[i].w] = vecs[i].exp_bcd;
    end
    tick();
    sample(1);
    check("done_one_cycle", 32'(o_done), 32'd0);
    check("valid_holds", 32'(o_valid), 32'd1);

    // Abort: start at cycle 0, en low in cycle 4, restart at cycle 6.
    drive(0, 1'b1, 7'd77);
    tick();
    drive(0, 1'b0, 7'd77);
    sample(0);
    check("abort_pre_busy", 32'(o_busy), 32'd1);
    repeat (3) tick();
    i0.en = 1'b0;
    tick();
    sample(0);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_valid", 32'(o_valid), 32'd0);
    check("abort_done", 32'(o_done), 32'd0);
    check("abort_bcd", 32'(o_bcd), 32'd0);
    i0.en = 1'b1;
    tick();
    sample(0);
    check("abort_no_done", 32'(o_done), 32'd0);
    conv(0, 7'd5, 12'h005, 1'b0, 12'h000);

    // Asynchronous reset in the middle of SHIFT.
    drive(0, 1'b1, 7'd88);
    tick();
    drive(0, 1'b0, 7'd88);
    tick();
    tick();
    sample(0);
    check("pre_rst_busy", 32'(o_busy), 32'd1);
    check("pre_rst_bcd", 32'(o_bcd), 32'h005);
    #1 rst_n = 1'b0;
    #1;
    sample(0);
    check("async_bcd", 32'(o_bcd), 32'd0);
    check("async_busy", 32'(o_busy), 32'd0);
    check("async_valid", 32'(o_valid), 32'd0);
    check("async_done", 32'(o_done), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      sample(0);
      if (o_done) nd++;
    end
    check("no_done_after_rst", 32'(nd), 32'd0);
    conv(0, 7'd88, 12'h088, 1'b0, 12'h000);

    // Self-start instance: 10, 10 again, then 37.
    ia.number = 7'd10;
    ia.en = 1'b1;
    nd = 0;
    cap[0] = 12'h000;
    cap[1] = 12'h000;
    for (int c = 0; c < 60; c++) begin
      if (c == 20) ia.number = 7'd10;
      if (c == 35) ia.number = 7'd37;
      tick();
      sample(2);
      if (o_done) begin
        if (nd < 2) cap[nd] = o_bcd;
        nd++;
      end
    end
    check("auto_conversions", 32'(nd), 32'd2);
    check("auto_first", 32'(cap[0]), 32'h010);
    check("auto_second", 32'(cap[1]), 32'h037);
    check("auto_valid", 32'(o_valid), 32'd1);
    check("auto_bcd", 32'(o_bcd), 32'h037);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
